// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a length-prefixed, checksummed byte stream into
// little-endian 32-bit words, writes them to program memory and releases the core on success.
module prog_loader #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic              memWriteEn,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memData,
  output logic              cpuReset,
  output logic              loadDone,
  output logic              loadErr
);

  typedef enum logic [2:0] {
    StIdle, StLen0, StLen1, StData, StCsum, StDone, StErr
  } state_e;

  state_e state_q, state_d;

  logic [15:0]       len_q;
  logic [ADDR_W:0]   widx_q;
  logic [ADDR_W:0]   widx_inc;
  logic [1:0]        lane_q;
  logic [7:0]        csum_q;
  logic [23:0]       word_q;
  logic              byte_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_data_q;
  logic              cpu_reset_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic [15:0]       len_full;

  assign accept   = byteValid & byte_ready_q;
  assign len_full = {byteIn, len_q[7:0]};
  assign widx_inc = widx_q + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: if (start) state_d = StLen0;
      StLen0: if (accept) state_d = StLen1;
      StLen1: begin
        if (accept) begin
          if (32'(len_full) > DEPTH)  state_d = StErr;
          else if (len_full == 16'd0) state_d = StCsum;
          else                        state_d = StData;
        end
      end
      StData: begin
        // Leave after the 4th byte of the final word.
        if (accept && lane_q == 2'd3 && 16'(widx_inc) == len_q) state_d = StCsum;
      end
      StCsum: if (accept) state_d = (byteIn == csum_q) ? StDone : StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      widx_q       <= '0;
      lane_q       <= '0;
      csum_q       <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= state_d inside {StLen0, StLen1, StData, StCsum};
      mem_we_q     <= 1'b0;
      case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            widx_q      <= '0;
            lane_q      <= '0;
            csum_q      <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        StLen0: if (accept) len_q[7:0] <= byteIn;
        StLen1: begin
          if (accept) begin
            len_q[15:8] <= byteIn;
            if (state_d == StErr) err_q <= 1'b1;
          end
        end
        StData: begin
          if (accept) begin
            csum_q <= csum_q ^ byteIn;
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= widx_q[ADDR_W-1:0];
              mem_data_q <= {byteIn, word_q};
              widx_q     <= widx_inc;
            end else begin
              word_q[8*lane_q +: 8] <= byteIn;
            end
          end
        end
        StCsum: begin
          if (accept) begin
            if (state_d == StDone) begin
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign byteReady  = byte_ready_q;
  assign memWriteEn = mem_we_q;
  assign memAddr    = mem_addr_q;
  assign memData    = mem_data_q;
  assign cpuReset   = cpu_reset_q;
  assign loadDone   = done_q;
  assign loadErr    = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: streams images with random words, gaps and checksum
// faults, and compares captured memory writes and status against a word-level model.
module tb_prog_loader;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        byteIn;
  logic              byteValid;
  logic              byteReady;
  logic              memWriteEn;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memData;
  logic              cpuReset;
  logic              loadDone;
  logic              loadErr;

  int total = 0;
  int bad   = 0;

  logic [31:0]       load_words [DEPTH];
  logic [ADDR_W-1:0] wr_addr [$];
  logic [31:0]       wr_data [$];

  prog_loader #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byteIn     (byteIn),
    .byteValid  (byteValid),
    .byteReady  (byteReady),
    .memWriteEn (memWriteEn),
    .memAddr    (memAddr),
    .memData    (memData),
    .cpuReset   (cpuReset),
    .loadDone   (loadDone),
    .loadErr    (loadErr)
  );

  always #5 clk = ~clk;

  // Capture every write strobe as seen by the memory.
  always @(negedge clk) begin
    if (memWriteEn === 1'b1) begin
      wr_addr.push_back(memAddr);
      wr_data.push_back(memData);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Offer one byte (optionally after idle gaps with random start noise); returns at the
  // negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit stalled);
    int g;
    int waited;
    g = gaps ? $urandom_range(0, 2) : 0;
    repeat (g) begin
      byteValid = 1'b0;
      byteIn    = 8'($urandom);
      start     = 1'($urandom);
      @(negedge clk);
    end
    start     = 1'b0;
    byteIn    = b;
    byteValid = 1'b1;
    waited    = 0;
    while (byteReady !== 1'b1 && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    stalled = (waited != 0);
    total++;
    if (byteReady !== 1'b1) begin
      bad++;
      $display("FAIL handshake timeout: byteReady=%b required 1", byteReady);
    end
    @(negedge clk);
  endtask

  // Full load of n words from load_words; cs_flip != 0 corrupts the checksum byte.
  task automatic do_load(input string name, input int n, input logic [7:0] cs_flip,
                         input bit gaps);
    logic [7:0] cs;
    bit         st;
    int         stalls;
    bit         cpu_ok;
    bit         exp_ok;
    int         nw;
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (byteReady !== 1'b1 || cpuReset !== 1'b1 || loadDone !== 1'b0 || loadErr !== 1'b0) begin
      bad++;
      $display("FAIL %s start: ready=%b cpuRst=%b done=%b err=%b required 1 1 0 0",
               name, byteReady, cpuReset, loadDone, loadErr);
    end
    cs     = 8'h00;
    stalls = 0;
    cpu_ok = 1'b1;
    send_byte(n[7:0], gaps, st);
    stalls += int'(st);
    send_byte(n[15:8], gaps, st);
    stalls += int'(st);
    if (n <= int'(DEPTH)) begin
      for (int w = 0; w < n; w++) begin
        for (int k = 0; k < 4; k++) begin
          cs = cs ^ load_words[w][8*k +: 8];
          send_byte(load_words[w][8*k +: 8], gaps, st);
          stalls += int'(st);
          if (cpuReset !== 1'b1) cpu_ok = 1'b0;
        end
      end
      send_byte(cs ^ cs_flip, gaps, st);
      stalls += int'(st);
    end
    byteValid = 1'b0;

    exp_ok = (n <= int'(DEPTH)) && (cs_flip == 8'h00);
    nw     = (n <= int'(DEPTH)) ? n : 0;
    total++;
    if (loadDone !== exp_ok || loadErr !== !exp_ok) begin
      bad++;
      $display("FAIL %s outcome: done=%b err=%b required done=%b err=%b",
               name, loadDone, loadErr, exp_ok, !exp_ok);
    end
    total++;
    if (cpuReset !== !exp_ok) begin
      bad++;
      $display("FAIL %s cpuReset: got %b required %b", name, cpuReset, !exp_ok);
    end
    total++;
    if (byteReady !== 1'b0) begin
      bad++;
      $display("FAIL %s ready_after: got %b required 0", name, byteReady);
    end
    total++;
    if (wr_addr.size() != nw) begin
      bad++;
      $display("FAIL %s write_count: got %0d required %0d", name, wr_addr.size(), nw);
    end else begin
      for (int i = 0; i < nw; i++) begin
        total++;
        if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== load_words[i]) begin
          bad++;
          $display("FAIL %s write[%0d]: got %h=%h required %h=%h",
                   name, i, wr_addr[i], wr_data[i], ADDR_W'(i), load_words[i]);
        end
      end
    end
    if (nw > 0) begin
      total++;
      if (memAddr !== ADDR_W'(nw - 1) || memData !== load_words[nw-1] || memWriteEn !== 1'b0) begin
        bad++;
        $display("FAIL %s hold: addr=%h data=%h we=%b required %h %h 0",
                 name, memAddr, memData, memWriteEn, ADDR_W'(nw - 1), load_words[nw-1]);
      end
    end
    total++;
    if (!cpu_ok) begin
      bad++;
      $display("FAIL %s cpu_held: cpuReset dropped during load, required 1 throughout", name);
    end
    if (!gaps) begin
      total++;
      if (stalls != 0) begin
        bad++;
        $display("FAIL %s back_to_back: stalls=%0d required 0", name, stalls);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    byteValid = 1'b0;
    byteIn    = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (byteReady !== 1'b0 || memWriteEn !== 1'b0 || memAddr !== '0 || memData !== 32'h0 ||
        cpuReset !== 1'b1 || loadDone !== 1'b0 || loadErr !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: rdy=%b we=%b a=%h d=%h cpu=%b done=%b err=%b required 0 0 0 0 1 0 0",
               byteReady, memWriteEn, memAddr, memData, cpuReset, loadDone, loadErr);
    end
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    for (int i = 0; i < 10; i++) begin
      byteValid = 1'($urandom);
      byteIn    = 8'($urandom);
      @(negedge clk);
      total++;
      if (byteReady !== 1'b0 || memWriteEn !== 1'b0 || cpuReset !== 1'b1) begin
        bad++;
        $display("FAIL idle[%0d]: rdy=%b we=%b cpu=%b required 0 0 1",
                 i, byteReady, memWriteEn, cpuReset);
      end
    end
    byteValid = 1'b0;
    total++;
    if (wr_addr.size() != 0) begin
      bad++;
      $display("FAIL idle_writes: got %0d required 0", wr_addr.size());
    end
  endtask

  task automatic test_directed();
    load_words[0] = 32'h0000_0013;
    load_words[1] = 32'h0050_00B3;
    do_load("dir_good", 2, 8'h00, 1'b0);
    // Flip by the true checksum so the transmitted byte is 0x00.
    do_load("dir_csum00", 2, 8'h13 ^ 8'hB3 ^ 8'h50, 1'b0);
  endtask

  task automatic test_overflow();
    do_load("over", int'(DEPTH) + 1, 8'h00, 1'b0);
  endtask

  task automatic test_zero_reload();
    do_load("zero", 0, 8'h00, 1'b1);
    load_words[0] = $urandom;
    do_load("reload", 1, 8'h00, 1'b1);
  endtask

  task automatic test_reset_midload();
    bit st;
    for (int i = 0; i < 3; i++) load_words[i] = $urandom;
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'd3, 1'b0, st);
    send_byte(8'd0, 1'b0, st);
    for (int k = 0; k < 4; k++) send_byte(load_words[0][8*k +: 8], 1'b0, st);
    for (int k = 0; k < 2; k++) send_byte(load_words[1][8*k +: 8], 1'b0, st);
    byteValid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    total++;
    if (byteReady !== 1'b0 || memWriteEn !== 1'b0 || memAddr !== '0 || memData !== 32'h0 ||
        cpuReset !== 1'b1 || loadDone !== 1'b0 || loadErr !== 1'b0) begin
      bad++;
      $display("FAIL midload_reset: rdy=%b we=%b a=%h d=%h cpu=%b done=%b err=%b required 0 0 0 0 1 0 0",
               byteReady, memWriteEn, memAddr, memData, cpuReset, loadDone, loadErr);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (wr_addr.size() != 1) begin
      bad++;
      $display("FAIL midload_writes: got %0d required 1", wr_addr.size());
    end else if (wr_addr[0] !== '0 || wr_data[0] !== load_words[0]) begin
      bad++;
      $display("FAIL midload_word0: got %h=%h required 00=%h", wr_addr[0], wr_data[0],
               load_words[0]);
    end
  endtask

  task automatic test_random();
    int         n;
    logic [7:0] flip;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) load_words[i] = $urandom;
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      do_load("rand", n, flip, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < int'(DEPTH); i++) load_words[i] = $urandom;
    do_load("full_depth", int'(DEPTH), 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_zero_reload();
    test_reset_midload();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
